// File: rtl/seq_detect_arbiter_4ch_if.sv
// rtl/seq_detect_arbiter_4ch_if.sv - request/grant and detection bus for the 4-channel 1101 detector
// Purpose : groups the per-channel serial request/grant signals and the detection outputs.
// Signals : en, in_valid[3:0], in_bit[3:0], clr[3:0]            (requester -> detector)
//           in_ready[3:0], det_valid, det_ch[1:0], hit_cnt[7:0] (detector -> requester)
// Modports: master = requester side, slave = detector side.
interface seq_detect_arbiter_4ch_if;
  logic       en;
  logic [3:0] in_valid;
  logic [3:0] in_bit;
  logic [3:0] clr;
  logic [3:0] in_ready;
  logic       det_valid;
  logic [1:0] det_ch;
  logic [7:0] hit_cnt;

  modport master (
    output en, in_valid, in_bit, clr,
    input  in_ready, det_valid, det_ch, hit_cnt
  );

  modport slave (
    input  en, in_valid, in_bit, clr,
    output in_ready, det_valid, det_ch, hit_cnt
  );
endinterface

// File: rtl/seq_detect_arbiter_4ch.sv
// rtl/seq_detect_arbiter_4ch.sv - 4-channel round-robin arbiter feeding one shared 1101 detector
// Purpose : grants one serial bit per cycle among 4 channels (round-robin) and runs a
//           shared overlapping 1101 detector over per-channel state registers.
// Ports   : clk   - clock
//           rst_n - asynchronous active-low reset
//           bus   - seq_detect_arbiter_4ch_if.slave (en, in_valid, in_bit, clr in;
//                   in_ready, det_valid, det_ch, hit_cnt out)
module seq_detect_arbiter_4ch (
  input  logic                      clk,
  input  logic                      rst_n,
  seq_detect_arbiter_4ch_if.slave   bus
);

  typedef enum logic [1:0] {
    S0 = 2'd0,  // idle
    S1 = 2'd1,  // seen "1"
    S2 = 2'd2,  // seen "11"
    S3 = 2'd3   // seen "110"
  } state_t;

  state_t     r_st [4];
  logic [1:0] r_ptr;
  logic       r_det_valid;
  logic [1:0] r_det_ch;
  logic [7:0] r_hit_cnt;

  logic [3:0] w_elig;
  logic       w_xfer;
  logic [1:0] w_gidx;
  logic [3:0] w_grant;
  logic       w_bit;
  state_t     w_cur;
  state_t     w_nxt;
  logic       w_hit;

  // Round-robin search starting at r_ptr; 2-bit addition wraps 3 -> 0.
  // Gating with rst_n keeps the grant at zero while reset is held.
  always_comb begin
    logic [1:0] idx;
    w_elig = (rst_n && bus.en) ? (bus.in_valid & ~bus.clr) : 4'b0000;
    w_xfer = 1'b0;
    w_gidx = 2'd0;
    idx    = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_xfer && w_elig[idx]) begin
        w_xfer = 1'b1;
        w_gidx = idx;
      end
    end
    w_grant = w_xfer ? (4'b0001 << w_gidx) : 4'b0000;
  end

  assign bus.in_ready = w_grant;

  // Shared next-state engine: only the granted channel's state is consulted.
  always_comb begin
    w_cur = r_st[w_gidx];
    w_bit = bus.in_bit[w_gidx];
    w_hit = 1'b0;
    w_nxt = S0;
    case (w_cur)
      S0: w_nxt = w_bit ? S1 : S0;
      S1: w_nxt = w_bit ? S2 : S0;
      S2: w_nxt = w_bit ? S2 : S3;
      S3: begin
        w_nxt = w_bit ? S1 : S0;  // S1 keeps the trailing '1' for overlap
        w_hit = w_bit;
      end
      default: w_nxt = S0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_st[i] <= S0;
      r_ptr       <= 2'd0;
      r_det_valid <= 1'b0;
      r_det_ch    <= 2'd0;
      r_hit_cnt   <= 8'd0;
    end else begin
      r_det_valid <= w_xfer && w_hit;
      if (w_xfer) begin
        r_st[w_gidx] <= w_nxt;
        r_ptr        <= w_gidx + 2'd1;
        if (w_hit) begin
          r_det_ch <= w_gidx;
          if (r_hit_cnt != 8'hFF) r_hit_cnt <= r_hit_cnt + 8'd1;
        end
      end
      // A cleared channel is never the granted one, so this cannot collide
      // with the update above.
      for (int i = 0; i < 4; i++) begin
        if (bus.clr[i]) r_st[i] <= S0;
      end
    end
  end

  assign bus.det_valid = r_det_valid;
  assign bus.det_ch    = r_det_ch;
  assign bus.hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_seq_detect_arbiter_4ch.sv
// tb/tb_seq_detect_arbiter_4ch.sv - self-checking bench for seq_detect_arbiter_4ch
module tb_seq_detect_arbiter_4ch;

  logic clk;
  logic rst_n;
  seq_detect_arbiter_4ch_if bus ();

  seq_detect_arbiter_4ch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: per-channel history of accepted bits since last clear/reset.
  int m_ptr;
  int m_len [4];
  logic [3:0] m_hist [4];
  int m_cnt;
  int m_dv;
  int m_dch;
  int m_g;

  int sq [4][$];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_dv  = 0;
    m_dch = 0;
    for (int i = 0; i < 4; i++) begin
      m_len[i]  = 0;
      m_hist[i] = 4'b0000;
    end
  endtask

  function automatic int model_grant(input logic e, input logic [3:0] v, input logic [3:0] c);
    logic [3:0] el;
    el = e ? (v & ~c) : 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (el[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check grant, model the edge, check outputs after it.
  task automatic cycle(input logic e, input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
    int exp_ready;
    bus.en       = e;
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.clr      = c;
    #1;
    m_g = model_grant(e, v, c);
    exp_ready = (m_g < 0) ? 0 : (1 << m_g);
    check_eq("in_ready", int'(bus.in_ready), exp_ready);
    @(posedge clk);
    m_dv = 0;
    if (m_g >= 0) begin
      m_hist[m_g] = {m_hist[m_g][2:0], b[m_g]};
      m_len[m_g]++;
      if (m_len[m_g] >= 4 && m_hist[m_g] == 4'b1101) begin
        m_dv  = 1;
        m_dch = m_g;
        if (m_cnt < 255) m_cnt++;
      end
      m_ptr = (m_g + 1) % 4;
    end
    for (int i = 0; i < 4; i++) begin
      if (c[i]) begin
        m_len[i]  = 0;
        m_hist[i] = 4'b0000;
      end
    end
    #1;
    check_eq("det_valid", int'(bus.det_valid), m_dv);
    check_eq("det_ch", int'(bus.det_ch), m_dch);
    check_eq("hit_cnt", int'(bus.hit_cnt), m_cnt);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.en       = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_bit   = 4'b1111;
    bus.clr      = 4'b0000;
    rst_n        = 1'b0;
    model_reset();
    #1;
    check_eq("rst_in_ready", int'(bus.in_ready), 0);
    check_eq("rst_det_valid", int'(bus.det_valid), 0);
    check_eq("rst_det_ch", int'(bus.det_ch), 0);
    check_eq("rst_hit_cnt", int'(bus.hit_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Feeds the queued bits; a channel requests while its queue is non-empty.
  task automatic run_streams(input int max_cyc);
    logic [3:0] v;
    logic [3:0] b;
    for (int n = 0; n < max_cyc; n++) begin
      v = 4'b0000;
      b = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (sq[i].size() > 0) begin
          v[i] = 1'b1;
          b[i] = sq[i][0][0];
        end
      end
      if (v == 4'b0000) break;
      cycle(1'b1, v, b, 4'b0000);
      if (m_g >= 0) void'(sq[m_g].pop_front());
    end
    for (int i = 0; i < 4; i++) check_eq("stream_drained", sq[i].size(), 0);
  endtask

  task automatic push_bits(input int ch, input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) sq[ch].push_back(int'(bits[k]));
  endtask

  int grant_seen [$];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.in_valid = 4'b0000;
    bus.in_bit = 4'b0000;
    bus.clr = 4'b0000;
    @(negedge clk);
    do_reset();

    // Channel 0 alone: 1101 -> one detection on channel 0.
    push_bits(0, 16'b1101, 4);
    run_streams(20);
    cycle(1'b1, 4'b0000, 4'b0000, 4'b0000);
    check_eq("r031_hit", int'(bus.hit_cnt), 1);

    // All four requesting; only ch2 carries 1101. Expect strict 0,1,2,3 rotation.
    do_reset();
    for (int i = 0; i < 4; i++) push_bits(i, (i == 2) ? 16'b1101 : 16'b0000, 4);
    for (int n = 0; n < 16; n++) begin
      logic [3:0] b;
      b = 4'b0000;
      for (int i = 0; i < 4; i++) if (sq[i].size() > 0) b[i] = sq[i][0][0];
      cycle(1'b1, 4'b1111, b, 4'b0000);
      check_eq("r032_order", m_g, n % 4);
      if (m_g >= 0) void'(sq[m_g].pop_front());
      if (n == 14) check_eq("r032_det_ch", int'(bus.det_ch), 2);
    end
    check_eq("r032_hit", int'(bus.hit_cnt), 1);

    // Overlap on channel 1: 1101101 -> two detections.
    do_reset();
    push_bits(1, 16'b1101101, 7);
    run_streams(20);
    check_eq("r033_hit", int'(bus.hit_cnt), 2);

    // Channel 3: 110, clear, 1 -> no detection; 101 then completes 1101.
    do_reset();
    push_bits(3, 16'b110, 3);
    run_streams(10);
    cycle(1'b1, 4'b1000, 4'b1000, 4'b1000);
    push_bits(3, 16'b1, 1);
    run_streams(10);
    check_eq("r034_clr_hit", int'(bus.hit_cnt), 0);
    push_bits(3, 16'b101, 3);
    run_streams(10);
    check_eq("r034_clr_s1", int'(bus.hit_cnt), 1);

    // Same with reset mid-pattern.
    do_reset();
    push_bits(3, 16'b110, 3);
    run_streams(10);
    do_reset();
    push_bits(3, 16'b1, 1);
    run_streams(10);
    check_eq("r034_rst_hit", int'(bus.hit_cnt), 0);

    // Saturation: 1101 then repeated 101 on ch0, 260 detections in all.
    do_reset();
    push_bits(0, 16'b1101, 4);
    for (int k = 0; k < 259; k++) push_bits(0, 16'b101, 3);
    run_streams(1000);
    check_eq("r035_sat", int'(bus.hit_cnt), 255);
    push_bits(0, 16'b101, 3);
    run_streams(10);
    check_eq("r035_pulse", int'(bus.det_valid), 1);
    check_eq("r035_hold", int'(bus.hit_cnt), 255);

    // Enable low with all requesting: nothing moves; resumes at held pointer.
    do_reset();
    cycle(1'b1, 4'b0011, 4'b0011, 4'b0000);
    for (int n = 0; n < 5; n++) cycle(1'b0, 4'b1111, 4'b1111, 4'b0000);
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0000);
    check_eq("r036_resume", m_g, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic e;
      logic [3:0] v;
      logic [3:0] b;
      logic [3:0] c;
      e = ($urandom_range(0, 9) != 0);
      v = 4'($urandom);
      b = 4'($urandom);
      c = 4'b0000;
      if (e && $urandom_range(0, 15) == 0) c = 4'($urandom);
      cycle(e, v, b, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_detect_arbiter_4ch.md
SEQ_DETECT_ARBITER_4CH -- requirements
Module: seq_detect_arbiter_4ch

Parameters
REQ-001 The block SHALL have no parameters: 4 channels, fixed pattern 1101, 8-bit hit counter.

Interface
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  global enable; 0 = no transfers, all state holds.
REQ-005 in_valid  input  4  per-channel request; bit i = channel i has a serial bit ready.
REQ-006 in_bit  input  4  per-channel serial data bit; bit i is sampled only on a channel-i transfer.
REQ-007 clr  input  4  per-channel synchronous clear of that channel's detector state.
REQ-008 in_ready  output  4  one-hot (or zero) grant; combinational from en, in_valid, clr and the RR pointer.
REQ-009 det_valid  output  1  registered one-cycle pulse: pattern 1101 completed.
REQ-010 det_ch  output  2  channel of the most recent detection; holds between detections.
REQ-011 hit_cnt  output  8  saturating count of all detections since reset.

Function
REQ-012 Transfer on channel i SHALL occur in a cycle where in_valid[i] & in_ready[i] = 1; at most one transfer per cycle.
REQ-013 The eligible set SHALL be in_valid & ~clr when en = 1, and empty when en = 0.
REQ-014 Grant: round-robin. Search the eligible set starting at the 2-bit pointer ptr and wrap 3->0; the first eligible channel gets in_ready; empty set -> in_ready = 4'b0000.
REQ-015 ptr SHALL update to (granted channel + 1) mod 4 on a transfer; ptr holds otherwise.
REQ-016 One shared next-state/detect engine SHALL serve all channels. It uses per-channel 2-bit state registers st[i]; only the granted channel's st is read and updated in a given cycle.
REQ-017 States: S0 = idle, S1 = "1", S2 = "11", S3 = "110".
REQ-018 Transitions on a transfer with bit b:
- S0: b=0 -> S0; b=1 -> S1.
- S1: b=0 -> S0; b=1 -> S2.
- S2: b=0 -> S3; b=1 -> S2.
- S3: b=0 -> S0; b=1 -> S1 with detection.
REQ-019 Overlap SHALL be supported as the S3->S1 transition defines. Example: 1101101 on one channel gives 2 detections.
REQ-020 On a detecting transfer, det_valid SHALL be 1 in the following cycle only. det_ch SHALL take the channel number on that same edge.
REQ-021 Latency: the edge that consumes the final '1' SHALL register det_valid. There are no back-to-back gaps; detections on consecutive cycles (different channels) SHALL produce consecutive det_valid pulses.
REQ-022 hit_cnt SHALL increment by 1 on each detecting transfer and saturate at 8'hFF (no wrap).
REQ-023 clr[i] SHALL force st[i] to S0 at the next edge. A cleared channel is never granted that cycle, so its in_bit is discarded. clr does not affect ptr, hit_cnt, det_ch or other channels.
REQ-024 st[i] of non-granted channels SHALL hold, regardless of in_valid or in_bit.
REQ-025 en = 0 SHALL hold ptr, all st[i] and hit_cnt, and drive det_valid 0 from the next edge. A detection registered on the edge before en fell still shows its pulse.
REQ-026 Simultaneous requests from all 4 channels SHALL be served in strict rotation, each once per 4 cycles. No channel starves while it holds in_valid.

Reset
REQ-027 rst_n = 0 SHALL asynchronously set st[0..3] = S0, ptr = 0, det_valid = 0, det_ch = 0, hit_cnt = 0.
REQ-028 While rst_n = 0, in_ready SHALL be 4'b0000.
REQ-029 Reset asserted mid-pattern SHALL discard partial progress. After release, a channel needs a full 1101 to detect.
REQ-030 Deassertion of rst_n SHALL be synchronised externally; the block takes effect from the first posedge after release.

Verification
REQ-031 Ch0 only, in_valid = 0001, bits 1,1,0,1 on 4 cycles -> det_valid = 1 for 1 cycle after the 4th transfer, det_ch = 0, hit_cnt = 1.
REQ-032 All in_valid = 1111 for 16 cycles; ch2 sends 1,1,0,1, others send 0 -> grant order 0,1,2,3 repeating; single det_valid with det_ch = 2 after the 15th transfer.
REQ-033 Ch1 sends 1,1,0,1,1,0,1 (overlap) -> exactly 2 detections, hit_cnt = 2.
REQ-034 Ch3 sends 1,1,0; clr[3] pulsed; then 1 -> no detection and st[3] ends in S1. Same sequence with rst_n pulsed low mid-pattern gives the same result and hit_cnt = 0.
REQ-035 256 detections on ch0, then more -> hit_cnt stops at 8'hFF; det_valid still pulses.
REQ-036 en = 0 with in_valid = 1111 for 5 cycles -> in_ready = 0000, ptr and st unchanged. After en = 1, grant resumes at the held ptr.
